// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline (ReLU / leaky / clipped / identity) over LANES signed lanes.
// Optional macro ACT_ZERO_STATS_EN adds a saturating zero_count port tracking zero-valued output lanes.
module activation_pipe #(
    parameter int unsigned DATA_W     = 21,
    parameter int unsigned LANES      = 1,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [1:0]                mode,
    input  logic [DATA_W-1:0]         clip,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data
`ifdef ACT_ZERO_STATS_EN
    ,
    output logic [31:0]               zero_count
`endif
);

    localparam int unsigned BUS_W = LANES * DATA_W;

    typedef enum logic [1:0] {
        MODE_RELU  = 2'b00,
        MODE_LEAKY = 2'b01,
        MODE_CLIP  = 2'b10,
        MODE_IDENT = 2'b11
    } mode_e;

    logic                     s1_valid_q, s1_valid_d;
    logic [BUS_W-1:0]         s1_data_q,  s1_data_d;
    mode_e                    s1_mode_q,  s1_mode_d;
    logic signed [DATA_W-1:0] s1_clip_q,  s1_clip_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [BUS_W-1:0]         s2_data_q,  s2_data_d;

    logic                     s1_adv, s2_adv;
    logic [BUS_W-1:0]         act_res;
    logic signed [DATA_W-1:0] lane_x, lane_y;

    // Ready chain is combinational from out_ready; no skid buffer.
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

    // Per-lane activation on the stage-1 beat, using that beat's own mode and clip.
    always_comb begin
        act_res = '0;
        lane_x  = '0;
        lane_y  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_x = s1_data_q[i*DATA_W +: DATA_W];
            case (s1_mode_q)
                MODE_RELU:  lane_y = lane_x[DATA_W-1] ? '0 : lane_x;
                MODE_LEAKY: lane_y = lane_x[DATA_W-1] ? (lane_x >>> LEAK_SHIFT) : lane_x;
                MODE_CLIP: begin
                    if (s1_clip_q[DATA_W-1] || lane_x[DATA_W-1]) begin
                        lane_y = '0;
                    end else if (lane_x > s1_clip_q) begin
                        lane_y = s1_clip_q;
                    end else begin
                        lane_y = lane_x;
                    end
                end
                MODE_IDENT: lane_y = lane_x;
            endcase
            act_res[i*DATA_W +: DATA_W] = lane_y;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_clip_d  = s1_clip_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = mode_e'(mode);
                s1_clip_d = clip;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = act_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_RELU;
            s1_clip_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_clip_q  <= s1_clip_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

`ifdef ACT_ZERO_STATS_EN
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [31:0]      zero_count_q, zero_count_d;
    logic [CNT_W-1:0] zero_lanes;
    logic [32:0]      zc_sum;

    // Count zero lanes of the beat leaving on this handshake; saturate at all-ones.
    always_comb begin
        zero_lanes = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (s2_data_q[i*DATA_W +: DATA_W] == '0) begin
                zero_lanes = zero_lanes + CNT_W'(1);
            end
        end
        zc_sum       = {1'b0, zero_count_q} + 33'(zero_lanes);
        zero_count_d = zero_count_q;
        if (s2_valid_q && out_ready) begin
            zero_count_d = zc_sum[32] ? 32'hFFFF_FFFF : zc_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_count_q <= '0;
        end else begin
            zero_count_q <= zero_count_d;
        end
    end

    assign zero_count = zero_count_q;
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe: directed table, latency/backpressure/reset sequences, random stream vs model.
// Exercises zero_count when ACT_ZERO_STATS_EN is defined.
module tb_activation_pipe;

    localparam int unsigned DATA_W     = 21;
    localparam int unsigned LEAK_SHIFT = 3;
    localparam int unsigned L4         = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0]   in_data, out_data, clip;
    logic [1:0]          mode;

    logic                in_valid4, in_ready4, out_valid4, out_ready4;
    logic [L4*DATA_W-1:0] in_data4, out_data4;
    logic [DATA_W-1:0]   clip4;
    logic [1:0]          mode4;

`ifdef ACT_ZERO_STATS_EN
    logic [31:0] zero_count, zero_count4;
`endif

    activation_pipe #(.DATA_W(DATA_W), .LANES(1), .LEAK_SHIFT(LEAK_SHIFT)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .clip(clip), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ACT_ZERO_STATS_EN
        , .zero_count(zero_count)
`endif
    );

    activation_pipe #(.DATA_W(DATA_W), .LANES(L4), .LEAK_SHIFT(LEAK_SHIFT)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .mode(mode4), .clip(clip4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
`ifdef ACT_ZERO_STATS_EN
        , .zero_count(zero_count4)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Activation rules in plain integer arithmetic; leaky uses floor division.
    function automatic logic [DATA_W-1:0] ref_act(input logic [1:0] m, input logic [DATA_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        int x, cv, r, dv, q;
        x  = int'($signed(d));
        cv = int'($signed(c));
        dv = 1 << LEAK_SHIFT;
        case (m)
            2'd0: r = (x < 0) ? 0 : x;
            2'd1: begin
                if (x < 0) begin
                    q = x / dv;
                    if (q * dv != x) q = q - 1;
                    r = q;
                end else begin
                    r = x;
                end
            end
            2'd2: begin
                if (cv < 0 || x < 0) r = 0;
                else if (x > cv)     r = cv;
                else                 r = x;
            end
            default: r = x;
        endcase
        return DATA_W'(r);
    endfunction

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int                model_zeros = 0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;
    bit                rand_bp = 1'b0;
    int                send_stalls = 0;

    // Scoreboard / stall monitor for the single-lane instance, sampled on the falling edge.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (rst) begin
            exp_q.delete();
            stall_prev  = 1'b0;
            model_zeros = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(stall_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("model_out", 64'(out_data), 64'(e));
                    got_q.push_back(out_data);
                    if (e == '0) model_zeros++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_act(mode, clip, in_data));
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic send(input logic [1:0] m, input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        logic acc;
        in_valid = 1'b1;
        mode     = m;
        clip     = c;
        in_data  = d;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) send_stalls++;
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("send_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [DATA_W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return DATA_W'(21'h100000);
            3: return DATA_W'(21'h0FFFFF);
            default: return DATA_W'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [1:0]        m;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] e;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [DATA_W-1:0] bp[4];
        logic [DATA_W-1:0] lanes_in[4];
        logic [DATA_W-1:0] lanes_exp[4];
        int idx;
        logic acc;

        tbl[0]  = '{2'd0, 21'd0,       21'h1FFFFF, 21'd0};
        tbl[1]  = '{2'd0, 21'd0,       21'h000005, 21'h000005};
        tbl[2]  = '{2'd0, 21'd0,       21'h100000, 21'd0};
        tbl[3]  = '{2'd0, 21'd0,       21'h0FFFFF, 21'h0FFFFF};
        tbl[4]  = '{2'd1, 21'd0,       21'h1FFFF0, 21'h1FFFFE};
        tbl[5]  = '{2'd1, 21'd0,       21'h1FFFFF, 21'h1FFFFF};
        tbl[6]  = '{2'd1, 21'd0,       21'd40,     21'd40};
        tbl[7]  = '{2'd2, 21'd100,     21'd250,    21'd100};
        tbl[8]  = '{2'd2, 21'd100,     21'd37,     21'd37};
        tbl[9]  = '{2'd2, 21'd100,     21'h1FFFF7, 21'd0};
        tbl[10] = '{2'd2, 21'h1FFFFF,  21'd5,      21'd0};
        tbl[11] = '{2'd2, 21'd100,     21'd100,    21'd100};
        tbl[12] = '{2'd1, 21'd0,       21'h1FFF9C, 21'h1FFFF3};
        tbl[13] = '{2'd3, 21'd0,       21'h1FFFF7, 21'h1FFFF7};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; mode = '0; clip = '0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_data4 = '0; mode4 = '0; clip4 = '0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", 64'(out_data), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid4", 64'(out_valid4), 64'(0));

        // Four-lane beat: ReLU then leaky, with zero statistics
        lanes_in[0] = 21'h1FFFFD; lanes_in[1] = 21'd0; lanes_in[2] = 21'd7; lanes_in[3] = 21'h1FFFFF;
        lanes_exp[0] = 21'd0;     lanes_exp[1] = 21'd0; lanes_exp[2] = 21'd7; lanes_exp[3] = 21'd0;
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        mode4 = 2'd0;
        for (int i = 0; i < 4; i++) in_data4[i*DATA_W +: DATA_W] = lanes_in[i];
        in_valid4 = 1'b1;
        @(negedge clk);
        check("l4_in_ready", 64'(in_ready4), 64'(1));
        @(posedge clk); #1 in_valid4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid4) break;
        end
        check("l4_out_valid", 64'(out_valid4), 64'(1));
        for (int i = 0; i < 4; i++) check("l4_relu_lane", 64'(out_data4[i*DATA_W +: DATA_W]), 64'(lanes_exp[i]));
`ifdef ACT_ZERO_STATS_EN
        check("l4_zero_count_before", 64'(zero_count4), 64'(0));
`endif
        @(posedge clk); #1;
`ifdef ACT_ZERO_STATS_EN
        check("l4_zero_count_after", 64'(zero_count4), 64'(3));
`endif
        lanes_in[0] = 21'h1FFFF0; lanes_in[1] = 21'd9; lanes_in[2] = 21'h1FFFFF; lanes_in[3] = 21'h1FFF9C;
        mode4 = 2'd1;
        for (int i = 0; i < 4; i++) in_data4[i*DATA_W +: DATA_W] = lanes_in[i];
        in_valid4 = 1'b1;
        @(posedge clk); #1 in_valid4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid4) break;
        end
        for (int i = 0; i < 4; i++)
            check("l4_leaky_lane", 64'(out_data4[i*DATA_W +: DATA_W]), 64'(ref_act(2'd1, '0, lanes_in[i])));
        @(posedge clk); #1;
`ifdef ACT_ZERO_STATS_EN
        check("l4_zero_count_hold", 64'(zero_count4), 64'(3));
`endif

        // Latency: beat driven in cycle c appears in cycle c+2
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 21'd5; mode = 2'd0; clip = '0;
        @(negedge clk);
        check("lat_c0_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("lat_c2_valid", 64'(out_valid), 64'(1));
        check("lat_c2_data", 64'(out_data), 64'(5));
        @(negedge clk);
        check("lat_c3_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        // Directed table streamed back to back
        got_q.delete();
        send_stalls = 0;
        for (int i = 0; i < 14; i++) send(tbl[i].m, tbl[i].c, tbl[i].x);
        check("table_no_bubble", 64'(send_stalls), 64'(0));
        drain();
        @(negedge clk);
        check("table_count", 64'(got_q.size()), 64'(14));
        for (int i = 0; i < 14 && i < got_q.size(); i++) check("table_vec", 64'(got_q[i]), 64'(tbl[i].e));
        @(posedge clk); #1;

        // Backpressure: out_ready low for 3 cycles while 4 beats are offered
        bp[0] = 21'd11; bp[1] = 21'h1FFFEE; bp[2] = 21'd33; bp[3] = 21'd44;
        got_q.delete();
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; mode = 2'd3; in_data = bp[0];
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) in_data = bp[idx];
            end
        end
        check("bp_accepts", 64'(idx), 64'(2));
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk); #1 out_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) in_data = bp[idx];
            end
        end
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("bp_count", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("bp_order", 64'(got_q[i]), 64'(bp[i]));
        @(posedge clk); #1;

        // Reset with both stages full
        out_ready = 1'b0;
        send(2'd3, '0, 21'd77);
        send(2'd3, '0, 21'd88);
        @(negedge clk);
        check("rst_full_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1 out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_no_stale", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;

        // Random stream with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) send(2'($urandom_range(0, 3)), pick_val(), pick_val());
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
`ifdef ACT_ZERO_STATS_EN
        check("zero_count_total", 64'(zero_count), 64'(model_zeros));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
